alt_vipitc131_common_avalon_mm_burst_slave: RTL and testbench



---
 rtl/alt_vipitc131_avmm_slave_pkg.sv | 27 ++
 rtl/alt_vipitc131_common_avalon_mm_burst_slave_if.sv | 31 +++
 rtl/alt_vipitc131_avmm_slave_ram.sv | 43 ++++
 rtl/alt_vipitc131_common_avalon_mm_burst_slave.sv | 156 +++++++++++++++
 tb/tb_alt_vipitc131_common_avalon_mm_burst_slave.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alt_vipitc131_avmm_slave_pkg.sv
// -----------------------------------------------------------------------------
// alt_vipitc131_avmm_slave_pkg
// Shared definitions for the burst-capable Avalon-MM slave:
//   - slave_state_e : FSM state encoding (IDLE / WRITE / READ)
//   - MAX_BURST     : largest legal burst for the default 6-bit burstcount
//   - max_burst()   : same rule for an arbitrary burstcount width
//   - BP_PERIOD     : backpressure counter value that forces waitrequest
//                     (only used when ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN)
// -----------------------------------------------------------------------------
package alt_vipitc131_avmm_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } slave_state_e;

    localparam int BURST_WIDTH_DFLT = 6;
    localparam int MAX_BURST        = 1 << (BURST_WIDTH_DFLT - 1);

    localparam logic [1:0] BP_PERIOD = 2'd3;

    function automatic int max_burst(input int burst_width);
        return 1 << (burst_width - 1);
    endfunction

endpackage

// File: rtl/alt_vipitc131_common_avalon_mm_burst_slave_if.sv
// -----------------------------------------------------------------------------
// alt_vipitc131_common_avalon_mm_burst_slave_if
// Avalon-MM bursting bus between a master and the burst slave.
//   master modport : drives address/burstcount/writedata/write/read,
//                    receives readdata/readdatavalid/waitrequest
//   slave modport  : the mirror image
// -----------------------------------------------------------------------------
interface alt_vipitc131_common_avalon_mm_burst_slave_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0]  av_address;
    logic [BURST_WIDTH-1:0] av_burstcount;
    logic [DATA_WIDTH-1:0]  av_writedata;
    logic                   av_write;
    logic                   av_read;
    logic [DATA_WIDTH-1:0]  av_readdata;
    logic                   av_readdatavalid;
    logic                   av_waitrequest;

    modport master (
        output av_address, av_burstcount, av_writedata, av_write, av_read,
        input  av_readdata, av_readdatavalid, av_waitrequest
    );

    modport slave (
        input  av_address, av_burstcount, av_writedata, av_write, av_read,
        output av_readdata, av_readdatavalid, av_waitrequest
    );
endinterface

// File: rtl/alt_vipitc131_avmm_slave_ram.sv
// -----------------------------------------------------------------------------
// alt_vipitc131_avmm_slave_ram
// Single-port word RAM with registered read (1-cycle latency).
//   clk     : clock
//   srst    : synchronous reset of the read-data register only (contents kept)
//   we_i    : write enable, mem[addr_i] <= wdata_i
//   re_i    : read enable, rdata_o <= mem[addr_i] on the next edge
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, holds between reads
// -----------------------------------------------------------------------------
module alt_vipitc131_avmm_slave_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Output register reset maps onto the block-RAM output-register reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/alt_vipitc131_common_avalon_mm_burst_slave.sv
// -----------------------------------------------------------------------------
// alt_vipitc131_common_avalon_mm_burst_slave
// Burst-capable Avalon-MM slave backed by on-chip word RAM. Absorbs write
// bursts (with idle gaps allowed) and returns read bursts on readdatavalid,
// beat k of a burst accepted in cycle N appearing in cycle N+1+k.
//   clock          : sole clock
//   reset          : synchronous, active-high
//   av (slave)     : Avalon-MM bursting bus (see the _if file)
//   busy           : FSM not idle or a read beat still in flight
//   protocol_error : sticky; burstcount==0, read+write together, or read
//                    during a write burst. Cleared only by reset.
// Build option: define ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN to force
// waitrequest every 4th cycle in IDLE/WRITE from a free-running counter.
// -----------------------------------------------------------------------------
module alt_vipitc131_common_avalon_mm_burst_slave
    import alt_vipitc131_avmm_slave_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int BURST_WIDTH    = 6,
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic clock,
    input  logic reset,
    alt_vipitc131_common_avalon_mm_burst_slave_if.slave av,
    output logic busy,
    output logic protocol_error
);
    slave_state_e              state_q;
    logic [BURST_WIDTH-1:0]    remaining_q;
    logic [MEM_DEPTH_LOG2-1:0] next_addr_q;
    logic                      rvalid_q;
    logic                      perr_q;
`ifdef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
    logic [1:0]                bp_cnt_q;
`endif

    logic                      waitreq;
    logic                      wr_beat;
    logic                      rd_cmd;
    logic                      bc_zero;
    logic                      bc_one;
    logic                      ram_we;
    logic                      ram_re;
    logic [MEM_DEPTH_LOG2-1:0] cmd_idx;
    logic [MEM_DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    // Address bits above the RAM index are don't-care.
    if (ADDR_WIDTH > MEM_DEPTH_LOG2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^av.av_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
    end

    always_comb begin
        cmd_idx = av.av_address[MEM_DEPTH_LOG2-1:0];
        bc_zero = (av.av_burstcount == '0);
        bc_one  = (av.av_burstcount == BURST_WIDTH'(1));

        // READ stalls new commands so the single RAM port is free for the
        // burst; the slave is also unavailable while reset is held.
        waitreq = reset || (state_q == READ);
`ifdef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
        if ((state_q != READ) && (bp_cnt_q == BP_PERIOD)) begin
            waitreq = 1'b1;
        end
`endif
        wr_beat = av.av_write && !waitreq;
        rd_cmd  = av.av_read && !av.av_write && !waitreq && (state_q == IDLE);

        // burstcount==0 consumes the beat without touching the RAM.
        ram_we   = wr_beat && ((state_q == WRITE) || !bc_zero);
        ram_re   = (rd_cmd && !bc_zero) || (state_q == READ);
        ram_addr = (state_q == IDLE) ? cmd_idx : next_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            next_addr_q <= '0;
            rvalid_q    <= 1'b0;
            perr_q      <= 1'b0;
`ifdef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
            bp_cnt_q    <= 2'd0;
`endif
        end else begin
            // RAM read latency is one cycle, so valid simply trails the issue.
            rvalid_q <= ram_re;
`ifdef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
            bp_cnt_q <= bp_cnt_q + 2'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (wr_beat) begin
                        if (av.av_read || bc_zero) begin
                            perr_q <= 1'b1;
                        end
                        if (!bc_zero && !bc_one) begin
                            remaining_q <= av.av_burstcount - BURST_WIDTH'(1);
                            next_addr_q <= cmd_idx + MEM_DEPTH_LOG2'(1);
                            state_q     <= WRITE;
                        end
                    end else if (rd_cmd) begin
                        if (bc_zero) begin
                            perr_q <= 1'b1;
                        end else if (!bc_one) begin
                            remaining_q <= av.av_burstcount - BURST_WIDTH'(1);
                            next_addr_q <= cmd_idx + MEM_DEPTH_LOG2'(1);
                            state_q     <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (av.av_read && !waitreq) begin
                        perr_q <= 1'b1;
                    end
                    if (wr_beat) begin
                        next_addr_q <= next_addr_q + MEM_DEPTH_LOG2'(1);
                        remaining_q <= remaining_q - BURST_WIDTH'(1);
                        if (remaining_q == BURST_WIDTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    next_addr_q <= next_addr_q + MEM_DEPTH_LOG2'(1);
                    remaining_q <= remaining_q - BURST_WIDTH'(1);
                    if (remaining_q == BURST_WIDTH'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    alt_vipitc131_avmm_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clock),
        .srst    (reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (av.av_writedata),
        .rdata_o (ram_rdata)
    );

    assign av.av_readdata      = ram_rdata;
    assign av.av_readdatavalid = rvalid_q;
    assign av.av_waitrequest   = waitreq;
    assign busy                = (state_q != IDLE) || rvalid_q;
    assign protocol_error      = perr_q;
endmodule

// File: tb/tb_alt_vipitc131_common_avalon_mm_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_alt_vipitc131_common_avalon_mm_burst_slave
// Drives directed and random bursts through the slave. A word-array model of
// the RAM plus a queue of (data, cycle) expectations predicts every read beat.
// -----------------------------------------------------------------------------
module tb_alt_vipitc131_common_avalon_mm_burst_slave;
    import alt_vipitc131_avmm_slave_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int BW    = 6;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic protocol_error;

    always #5 clock = ~clock;

    alt_vipitc131_common_avalon_mm_burst_slave_if #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BURST_WIDTH (BW)
    ) av_if ();

    alt_vipitc131_common_avalon_mm_burst_slave #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BURST_WIDTH (BW), .MEM_DEPTH_LOG2 (DL)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .av             (av_if),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    int            vectors    = 0;
    int            miscompares = 0;
    int            cyc        = 0;
    logic [DW-1:0] model [DEPTH];
    exp_t          exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Read-return monitor: every valid beat must match the head expectation
    // both in data and in the cycle it was predicted for.
    always @(negedge clock) begin : mon
        exp_t e;
        if (av_if.av_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(av_if.av_readdata), 32'(e.data));
                check("rd_cycle", cyc, e.cyc);
                $display("rd beat data=0x%04h cyc=%0d", av_if.av_readdata, cyc);
            end
        end
    end

    task automatic wait_accept(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (av_if.av_waitrequest === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int bc,
                            input logic [DW-1:0] base, input bit rnd, input bit gaps);
        int            nb;
        bit            ok;
        logic [DW-1:0] d;
        nb = (bc == 0) ? 1 : bc;
        av_if.av_address    = addr;
        av_if.av_burstcount = BW'(bc);
        for (int i = 0; i < nb; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                av_if.av_write = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
            d = rnd ? DW'($urandom) : base + DW'(i);
            av_if.av_write     = 1'b1;
            av_if.av_writedata = d;
            wait_accept("wr_accept", ok);
            if (ok && bc != 0) model[(int'(addr) + i) % DEPTH] = d;
            @(posedge clock);
            #1;
        end
        av_if.av_write = 1'b0;
        $display("wr burst addr=0x%04h bc=%0d", addr, bc);
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int bc, output int acc_cyc);
        bit ok;
        av_if.av_address    = addr;
        av_if.av_burstcount = BW'(bc);
        av_if.av_read       = 1'b1;
        wait_accept("rd_accept", ok);
        acc_cyc = cyc;
        if (ok) begin
            for (int k = 0; k < bc; k++) begin
                exp_q.push_back('{model[(int'(addr) + k) % DEPTH], cyc + 1 + k});
            end
        end
        @(posedge clock);
        #1;
        av_if.av_read = 1'b0;
        $display("rd cmd addr=0x%04h bc=%0d accepted cyc=%0d", addr, bc, acc_cyc);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        bit ok;
        av_if.av_address    = '0;
        av_if.av_burstcount = '0;
        av_if.av_writedata  = '0;
        av_if.av_write      = 1'b0;
        av_if.av_read       = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_waitreq", 32'(av_if.av_waitrequest), 32'd1);
        check("rst_rvalid", 32'(av_if.av_readdatavalid), 32'd0);
        check("rst_rdata", 32'(av_if.av_readdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_perr", 32'(protocol_error), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_waitreq", 32'(av_if.av_waitrequest), 32'd0);
        @(posedge clock);
        #1;

        // Write 0xA0..0xA3 at 0x10, read back with exact timing
        wr_burst(16'h0010, 4, 16'h00A0, 1'b0, 1'b0);
        rd_burst(16'h0010, 4, a0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("rd_burst_waitreq", 32'(av_if.av_waitrequest), 32'd1);
            check("rd_burst_busy", 32'(busy), 32'd1);
        end
`ifndef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
        @(negedge clock);
        check("rd_burst_waitreq_end", 32'(av_if.av_waitrequest), 32'd0);
`endif
        drain();

        // Back-to-back B=2 reads: second accepted exactly 2 cycles later
        wr_burst(16'h0040, 4, 16'h0, 1'b1, 1'b0);
        rd_burst(16'h0040, 2, a0);
        rd_burst(16'h0042, 2, a1);
        check("b2b_accept_gap", a1 - a0, 2);
        drain();

        // Wrap across the top of RAM
        wr_burst(16'h00FE, 4, 16'h00B0, 1'b0, 1'b1);
        rd_burst(16'h00FE, 4, a0);
        drain();
        rd_burst(16'h0000, 1, a0);
        rd_burst(16'h0001, 1, a0);
        drain();

        // Protocol errors: burstcount 0 write, then read+write together
        @(negedge clock);
        check("perr_clear", 32'(protocol_error), 32'd0);
        @(posedge clock);
        #1;
        wr_burst(16'h0030, 1, 16'h1111, 1'b0, 1'b0);
        wr_burst(16'h0030, 0, 16'h2222, 1'b0, 1'b0);
        @(negedge clock);
        check("perr_bc0", 32'(protocol_error), 32'd1);
        @(posedge clock);
        #1;
        av_if.av_address    = 16'h0031;
        av_if.av_burstcount = BW'(1);
        av_if.av_writedata  = 16'h3333;
        av_if.av_write      = 1'b1;
        av_if.av_read       = 1'b1;
        wait_accept("rdwr_accept", ok);
        if (ok) model[16'h31] = 16'h3333;
        @(posedge clock);
        #1;
        av_if.av_write = 1'b0;
        av_if.av_read  = 1'b0;
        @(posedge clock);
        #1;
        rd_burst(16'h0030, 1, a0);
        rd_burst(16'h0031, 1, a0);
        drain();
        @(negedge clock);
        check("perr_sticky", 32'(protocol_error), 32'd1);
        @(posedge clock);
        #1;

        // Reset during beat 2 of an 8-beat read
        wr_burst(16'h0080, 8, 16'h0, 1'b1, 1'b0);
        rd_burst(16'h0080, 8, a0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("midrst_rvalid", 32'(av_if.av_readdatavalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_perr", 32'(protocol_error), 32'd0);
        check("midrst_waitreq", 32'(av_if.av_waitrequest), 32'd0);
        @(posedge clock);
        #1;
        rd_burst(16'h0080, 3, a0);
        drain();

`ifdef ALT_VIPITC131_AVMM_SLAVE_BACKPRESSURE_EN
        // Backpressure: one stall in every 4 idle cycles
        a1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (av_if.av_waitrequest === 1'b1) a1++;
        end
        check("bp_stall_count", a1, 2);
        @(posedge clock);
        #1;
        wr_burst(16'h0060, 8, 16'h0, 1'b1, 1'b0);
        rd_burst(16'h0060, 8, a0);
        drain();
`endif

        // Random mix of write bursts and read bursts against the model
        for (int t = 0; t < 120; t++) begin
            logic [AW-1:0] ra;
            int            rb;
            ra = AW'($urandom);
            rb = $urandom_range(1, MAX_BURST / 2);
            if ($urandom_range(0, 1) == 0) begin
                wr_burst(ra, rb, 16'h0, 1'b1, 1'b1);
            end else begin
                rd_burst(ra, rb, a0);
                if ($urandom_range(0, 3) == 0) drain();
            end
        end
        drain();
        @(negedge clock);
        check("final_busy", 32'(busy), 32'd0);
        check("final_perr", 32'(protocol_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
